uart_rx: RTL

- Asynchronous serial receiver: the receive-side counterpart of the existing `uart` transmit path (`i_tx_enable`, `i_data`).
- Samples the serial line and decodes 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, idle-high line.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the byte consumer. Loopback with `uart` is the primary integration test.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit paths so both ends
// agree on frame format and default baud divisor.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// lets the caller pick the line's idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-bit validation at mid-bit, LSB-first data,
// stop-bit check with framing-error pulse and break hold-off.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q;
    logic [CW-1:0]        clk_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    // A start bit that is no longer low at mid-bit was noise.
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    // Leaving mid-stop-bit leaves half a bit to catch a
                    // start edge that follows with no idle gap.
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                BREAK: begin
                    clk_cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    clk_cnt_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != IDLE);

endmodule
